// File: rtl/dice_game_ctrl_pkg.sv
// Shared definitions for the two-player dice controller.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package dice_game_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROLL,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [2:0] DICE_MIN = 3'd1;
   localparam logic [2:0] DICE_MAX = 3'd6;

   // A dice face is only meaningful in 1..6; 0 and 7 indicate a glitched read.
   function automatic logic is_legal_throw(input logic [2:0] t);
      return (t >= DICE_MIN) && (t <= DICE_MAX);
   endfunction

endpackage

// File: rtl/dice_game_ctrl_roll_timer.sv
// Saturating cycle counter flagging when a timed interval has elapsed.
// Latency: done rises CYCLES-1 enabled cycles after clear.
// Backpressure: none; holds at the final count while enabled.
module roll_timer #(
   parameter int CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] cnt;

   // Count up while enabled, stopping at the last value; clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign done = (cnt == LAST);

endmodule

// File: rtl/dice_game_ctrl.sv
// Two-player turn scheduler: arbitrates the dice, times rolls, scores, picks a winner.
// Latency: press edge to result_valid is MIN_ROLL_CYCLES+2 cycles minimum.
// Backpressure: none; the inactive button and all buttons after a win are ignored.
module dice_game_ctrl
   import dice_game_ctrl_pkg::*;
#(
   parameter int MIN_ROLL_CYCLES = 8,
   parameter int TARGET_SCORE    = 20,
   parameter int SCORE_W         = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_p0,
   input  logic               btn_p1,
   input  logic               new_game,
   input  logic [2:0]         throw,
   output logic               roll_en,
   output logic               active_player,
   output logic [2:0]         result,
   output logic               result_valid,
   output logic               bad_throw,
   output logic [SCORE_W-1:0] score0,
   output logic [SCORE_W-1:0] score1,
   output logic               game_over,
   output logic               winner
);

   state_t             state, state_n;
   logic               roll_en_n, active_n, result_valid_n, bad_throw_n;
   logic               game_over_n, winner_n;
   logic [2:0]         result_n;
   logic [SCORE_W-1:0] score0_n, score1_n;
   logic [SCORE_W-1:0] sum;
   logic               act_btn;
   logic               roll_done;

   // The counter only runs in ROLL; it sits at zero everywhere else.
   roll_timer #(
      .CYCLES(MIN_ROLL_CYCLES)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  ((state != ROLL) || new_game),
      .en   (state == ROLL),
      .done (roll_done)
   );

   assign act_btn = active_player ? btn_p1 : btn_p0;
   assign sum     = (active_player ? score1 : score0) + SCORE_W'(throw);

   // Next-state and next-output decode; new_game overrides every state.
   always_comb begin
      state_n        = state;
      roll_en_n      = roll_en;
      active_n       = active_player;
      result_n       = result;
      result_valid_n = 1'b0;
      bad_throw_n    = 1'b0;
      score0_n       = score0;
      score1_n       = score1;
      game_over_n    = game_over;
      winner_n       = winner;
      if (new_game) begin
         state_n     = IDLE;
         roll_en_n   = 1'b0;
         active_n    = 1'b0;
         result_n    = '0;
         score0_n    = '0;
         score1_n    = '0;
         game_over_n = 1'b0;
         winner_n    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (act_btn) begin
                  state_n   = ROLL;
                  roll_en_n = 1'b1;
               end
            end
            ROLL: begin
               if (roll_done && !act_btn) begin
                  state_n   = SETTLE;
                  roll_en_n = 1'b0;
               end
            end
            SETTLE: state_n = SAMPLE;
            SAMPLE: begin
               if (is_legal_throw(throw)) begin
                  result_n       = throw;
                  result_valid_n = 1'b1;
                  if (active_player) score1_n = sum;
                  else               score0_n = sum;
                  if (sum >= SCORE_W'(TARGET_SCORE)) begin
                     state_n     = DONE;
                     game_over_n = 1'b1;
                     winner_n    = active_player;
                  end else begin
                     state_n  = IDLE;
                     active_n = ~active_player;
                  end
               end else begin
                  bad_throw_n = 1'b1;
                  state_n     = IDLE;
               end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         roll_en       <= 1'b0;
         active_player <= 1'b0;
         result        <= '0;
         result_valid  <= 1'b0;
         bad_throw     <= 1'b0;
         score0        <= '0;
         score1        <= '0;
         game_over     <= 1'b0;
         winner        <= 1'b0;
      end else begin
         state         <= state_n;
         roll_en       <= roll_en_n;
         active_player <= active_n;
         result        <= result_n;
         result_valid  <= result_valid_n;
         bad_throw     <= bad_throw_n;
         score0        <= score0_n;
         score1        <= score1_n;
         game_over     <= game_over_n;
         winner        <= winner_n;
      end
   end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: table of turns plus hand sequences.
// Latency: expected turn records are queued at press time and checked on each result event.
// Backpressure: not applicable.
module tb_dice_game_ctrl;

   localparam int M = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_p0 = 1'b0, btn_p1 = 1'b0, new_game = 1'b0;
   logic [2:0] throw = 3'd0;
   logic       roll_en, active_player, result_valid, bad_throw, game_over, winner;
   logic [2:0] result;
   logic [5:0] score0, score1;

   dice_game_ctrl #(.MIN_ROLL_CYCLES(M), .TARGET_SCORE(20), .SCORE_W(6)) dut (
      .clk(clk), .rst(rst), .btn_p0(btn_p0), .btn_p1(btn_p1), .new_game(new_game),
      .throw(throw), .roll_en(roll_en), .active_player(active_player), .result(result),
      .result_valid(result_valid), .bad_throw(bad_throw), .score0(score0), .score1(score1),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       p;     // button pressed
      bit [2:0] t;     // throw presented
      int       hold;  // edges the button is sampled high
      bit       bad;
      bit [2:0] res;
      int       s0;
      int       s1;
      bit       act;
      bit       over;
      bit       win;
   } vec_t;

   typedef struct {
      vec_t v;
      int   len;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;
   bit   prev_roll = 1'b0;
   int   run = 0, last_run = 0, lat = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Track roll_en run length and press-to-event latency, and score each event.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_roll = 1'b0;
         lat       = 0;
         run       = 0;
      end else begin
         if (roll_en && !prev_roll) lat = 0;
         else lat++;
         if (!roll_en && prev_roll) last_run = run;
         if (roll_en) run = prev_roll ? run + 1 : 1;
         prev_roll = roll_en;
         if (result_valid || bad_throw) begin
            if (q.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = q.pop_front();
               check("bad_throw", bad_throw, e.v.bad);
               check("result_valid", result_valid, !e.v.bad);
               check("result", result, e.v.res);
               check("score0", score0, e.v.s0);
               check("score1", score1, e.v.s1);
               check("active_player", active_player, e.v.act);
               check("game_over", game_over, e.v.over);
               check("winner", winner, e.v.win);
               check("roll_len", last_run, e.len);
               check("latency", lat, e.len + 2);
            end
         end
      end
   end

   task automatic play_turn(input vec_t v);
      exp_t e;
      e.v   = v;
      e.len = (v.hold > M) ? v.hold : M;
      q.push_back(e);
      @(posedge clk); #1;
      throw = v.t;
      if (v.p) btn_p1 = 1'b1; else btn_p0 = 1'b1;
      repeat (v.hold) @(posedge clk);
      #1;
      btn_p0 = 1'b0;
      btn_p1 = 1'b0;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         check("event_timeout", 0, 1);
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Press a button for n edges and return how many cycles roll_en was seen high.
   task automatic press_count(input bit p0, input bit p1, input int n, output int highs);
      highs = 0;
      @(posedge clk); #1;
      btn_p0 = p0;
      btn_p1 = p1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (roll_en) highs++;
      end
      @(posedge clk); #1;
      btn_p0 = 1'b0;
      btn_p1 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (roll_en) highs++;
      end
   endtask

   vec_t tbl[9];
   int   highs;

   initial begin
      //            p  t  hold bad res s0  s1 act over win
      tbl[0] = '{1'b0, 3'd4, 3,  1'b0, 3'd4, 4,  0,  1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 3'd7, 1,  1'b1, 3'd4, 4,  0,  1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 3'd6, 20, 1'b0, 3'd6, 4,  6,  1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 3'd0, 8,  1'b1, 3'd6, 4,  6,  1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 3'd6, 9,  1'b0, 3'd6, 10, 6,  1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 3'd3, 2,  1'b0, 3'd3, 10, 9,  1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 3'd6, 5,  1'b0, 3'd6, 16, 9,  1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 3'd2, 1,  1'b0, 3'd2, 16, 11, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 3'd5, 4,  1'b0, 3'd5, 21, 11, 1'b0, 1'b1, 1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_roll_en", roll_en, 0);
      check("rst_active", active_player, 0);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_bad", bad_throw, 0);
      check("rst_score0", score0, 0);
      check("rst_score1", score1, 0);
      check("rst_over", game_over, 0);
      check("rst_winner", winner, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Full game from the table, ending in a player 0 win at 21.
      for (int i = 0; i < 9; i++) play_turn(tbl[i]);

      // After the win every button is ignored and outputs hold.
      press_count(1'b1, 1'b1, 12, highs);
      check("done_roll_en", highs, 0);
      check("done_over", game_over, 1);
      check("done_winner", winner, 0);
      check("done_score0", score0, 21);
      check("done_score1", score1, 11);

      // new_game from DONE clears everything.
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      check("ng_over", game_over, 0);
      check("ng_score0", score0, 0);
      check("ng_result", result, 0);
      check("ng_active", active_player, 0);

      // Player 0 takes one turn, then the inactive player 0 button is ignored.
      play_turn('{1'b0, 3'd1, 2, 1'b0, 3'd1, 1, 0, 1'b1, 1'b0, 1'b0});
      press_count(1'b1, 1'b0, 6, highs);
      check("wrong_player_roll_en", highs, 0);
      check("wrong_player_active", active_player, 1);
      play_turn('{1'b1, 3'd6, 3, 1'b0, 3'd6, 1, 6, 1'b0, 1'b0, 1'b0});
      play_turn('{1'b0, 3'd2, 3, 1'b0, 3'd2, 3, 6, 1'b1, 1'b0, 1'b0});
      play_turn('{1'b1, 3'd3, 3, 1'b0, 3'd3, 3, 9, 1'b0, 1'b0, 1'b0});
      check("pre_ng_score1", score1, 9);

      // new_game mid-roll drops roll_en at the same edge.
      btn_p0 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("midroll_roll_en", roll_en, 1);
      new_game = 1'b1;
      btn_p0   = 1'b0;
      @(posedge clk); #1;
      new_game = 1'b0;
      check("midroll_ng_roll_en", roll_en, 0);
      check("midroll_ng_score0", score0, 0);
      check("midroll_ng_score1", score1, 0);
      check("midroll_ng_active", active_player, 0);
      repeat (3) @(posedge clk);
      #1;
      check("midroll_ng_idle", roll_en, 0);

      // new_game and a press in the same cycle: the press is lost.
      new_game = 1'b1;
      btn_p0   = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      btn_p0   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ng_press_roll_en", roll_en, 0);
      repeat (20) @(posedge clk);
      check("leftover_events", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dice_game_ctrl.md
Name: dice_game_ctrl

Overview:
- Two-player turn scheduler for the electronic dice roller, which rolls while its button input is high.
- Arbitrates the single dice between two player buttons and drives the dice button through roll_en.
- Enforces a minimum roll time, latches each settled throw, accumulates per-player scores, and declares a winner at a target score.
- Sits between the board push-buttons and the dice roller; outputs feed the display logic.

Parameters:
- MIN_ROLL_CYCLES, 8: minimum cycles roll_en stays high per turn (≥2).
- TARGET_SCORE, 20: score at or above which the active player wins.
- SCORE_W, 6: score register width; must hold TARGET_SCORE+5.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_p0  in  1  player 0 roll button, already synchronised
- btn_p1  in  1  player 1 roll button, already synchronised
- new_game  in  1  single-cycle pulse; restart the game
- throw  in  3  current dice value, legal range 1..6
- roll_en  out  1  registered; drives the dice button input
- active_player  out  1  player whose turn it is
- result  out  3  last accepted throw
- result_valid  out  1  one-cycle pulse when result updates
- bad_throw  out  1  one-cycle pulse when an illegal throw is sampled
- score0  out  SCORE_W  player 0 total
- score1  out  SCORE_W  player 1 total
- game_over  out  1  high while a winner is declared
- winner  out  1  winning player, valid while game_over

Behaviour:
- Reset values: all outputs 0; state IDLE; roll counter 0.
- States: IDLE, ROLL, SETTLE, SAMPLE, DONE.
- IDLE:
  - Active player's button high at an edge → ROLL; roll_en=1 from that edge; counter cleared.
  - The other player's button is ignored in every state.
- ROLL:
  - Counter increments each cycle, saturating at MIN_ROLL_CYCLES-1.
  - Leave when counter==MIN_ROLL_CYCLES-1 and active button low → SETTLE; roll_en=0 from that edge.
  - Holding the button extends the roll indefinitely.
  - Releasing the button early does not end the roll.
- SETTLE:
  - Lasts one cycle; absorbs the final dice advance caused by registered roll_en → SAMPLE.
- SAMPLE: captures throw on the edge leaving the state.
  - Throw 1..6:
    - result<=throw; result_valid pulses.
    - Add throw to the active player's score.
    - New score ≥ TARGET_SCORE → DONE; winner<=active_player; game_over<=1.
    - Otherwise active_player toggles → IDLE.
  - Throw 0 or 7:
    - bad_throw pulses; no score change; result unchanged.
    - Same player → IDLE, to re-roll.
- DONE:
  - Buttons ignored; outputs hold until new_game.
- new_game (any state, highest priority after rst):
  - Next edge clears scores, result, game_over, winner and roll_en; active_player=0; state IDLE.
  - Mid-roll, roll_en drops at that same edge.
- Score addition is SCORE_W-bit unsigned; no overflow possible given the SCORE_W rule.
- Minimum turn: press-edge to result_valid is MIN_ROLL_CYCLES+2 cycles.
- Simultaneous events:
  - new_game and a button press in the same cycle: new_game wins; the press is ignored.
  - Both buttons pressed: only the active player's button counts.

Decomposition:
- Shared dice package holds:
  - state encoding enum (IDLE..DONE);
  - constants DICE_MIN=3'd1, DICE_MAX=3'd6;
  - an is_legal_throw function.
- One natural sub-module: roll_timer (counter, clear/enable inputs, done output at MIN_ROLL_CYCLES-1), reusable for other timed UI.
- Score accumulation and the FSM stay in dice_game_ctrl.

Test Plan:
- Reset, then btn_p0 held 3 cycles, throw=4 → roll_en high exactly 8 cycles; result=4, result_valid 1 pulse at cycle 10; score0=4; active_player=1.
- btn_p0 pressed while active_player=1 → roll_en stays 0; no state change; btn_p1 press then starts the roll.
- Active button held 20 cycles → roll_en high 20 cycles; falls the edge after release; sample 2 edges later.
- throw forced to 7 at SAMPLE → bad_throw pulses; scores unchanged; active_player unchanged; next press re-rolls.
- score0=16, player 0 throws 5 → score0=21; game_over=1; winner=0; further btn_p0/btn_p1 presses ignored.
- new_game pulsed mid-ROLL with score1=9 → roll_en 0 the next cycle; all scores 0; active_player=0; state IDLE.
